wb_stage: RTL

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_stage.sv | 85 ++++++++
 1 files changed

// File: rtl/wb_stage.sv
// wb_stage: MIPS write-back stage with register-file write, ID bypass buffer and sticky halt.
// Optional retired-instruction counter enabled by defining WB_RETIRE_CNT_EN.
module wb_stage (
   input  logic        CLK,
   input  logic        RST,
   input  logic        wb_en,
   input  logic        RegWrite,
   input  logic        memToReg,
   input  logic        jal,
   input  logic        lui,
   input  logic        halt,
   input  logic [1:0]  RegDest,
   input  logic [4:0]  rd,
   input  logic [4:0]  rt,
   input  logic [15:0] imm,
   input  logic [31:0] next_pc,
   input  logic [31:0] port_out,
   input  logic [31:0] dmemload,
   output logic        rf_WEN,
   output logic [4:0]  rf_wsel,
   output logic [31:0] rf_wdat,
   output logic        fwd_valid,
   output logic [4:0]  fwd_sel,
   output logic [31:0] fwd_dat,
   output logic        halt_out,
   output logic [31:0] retired
);
   typedef enum logic {RUN, HALTED} state_t;
   state_t      r_state;
   logic        r_halt;
   logic        r_fwd_valid;
   logic [4:0]  r_fwd_sel;
   logic [31:0] r_fwd_dat;
   logic [4:0]  w_dest;
   logic [31:0] w_wdat;
   logic        w_commit;

   always_comb begin
      w_dest   = jal ? 5'd31 : RegDest == 2'b01 ? rd : RegDest == 2'b10 ? 5'd31 : rt;
      w_wdat   = jal ? next_pc : lui ? {imm, 16'h0000} : memToReg ? dmemload : port_out;
      w_commit = r_state == RUN && wb_en && RegWrite && !halt && w_dest != 5'd0;
   end

   assign rf_WEN    = w_commit;
   assign rf_wsel   = w_dest;
   assign rf_wdat   = w_wdat;
   assign fwd_valid = r_fwd_valid;
   assign fwd_sel   = r_fwd_sel;
   assign fwd_dat   = r_fwd_dat;
   assign halt_out  = r_halt;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state     <= RUN;
         r_halt      <= 1'b0;
         r_fwd_valid <= 1'b0;
         r_fwd_sel   <= '0;
         r_fwd_dat   <= '0;
      end else begin
         r_fwd_valid <= w_commit;
         if (w_commit) begin
            r_fwd_sel <= w_dest;
            r_fwd_dat <= w_wdat;
         end
         if (r_state == RUN && wb_en && halt) begin
            r_state <= HALTED;
            r_halt  <= 1'b1;
         end
      end
   end

`ifdef WB_RETIRE_CNT_EN
   logic [31:0] r_retired;
   // Counts every issued instruction in RUN, halt included; saturates.
   always_ff @(posedge CLK) begin
      if (RST)
         r_retired <= '0;
      else if (r_state == RUN && wb_en && r_retired != 32'hFFFF_FFFF)
         r_retired <= r_retired + 32'd1;
   end
   assign retired = r_retired;
`else
   assign retired = '0;
`endif
endmodule
